// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port among the instruction fetcher,
// the LSB (loads) and ROB commit (stores). Request pulses are latched as
// pending and arbitrated store > load > fetch. Each access is serialised into
// little-endian byte beats, and a one-cycle done pulse goes back to the winner.
module mem_arbiter #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_flush,
  input  logic                  in_fetch_ce,
  input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
  output logic                  out_fetch_ce,
  output logic [31:0]           out_fetch_data,
  input  logic                  in_lsb_ce,
  input  logic [2:0]            in_lsb_size,
  input  logic                  in_lsb_signed,
  input  logic [ADDR_WIDTH-1:0] in_lsb_addr,
  output logic                  out_lsb_ce,
  output logic [31:0]           out_lsb_data,
  input  logic                  in_rob_ce,
  input  logic [2:0]            in_rob_size,
  input  logic [ADDR_WIDTH-1:0] in_rob_addr,
  input  logic [31:0]           in_rob_data,
  output logic                  out_rob_ce,
  input  logic [7:0]            in_ram_data,
  output logic [7:0]            out_ram_data,
  output logic [ADDR_WIDTH-1:0] out_ram_addr,
  output logic                  out_ram_wr,
  input  logic                  in_io_buffer_full
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} state_t;

  localparam logic [1:0] WHO_FETCH = 2'd0;
  localparam logic [1:0] WHO_LSB   = 2'd1;
  localparam logic [1:0] WHO_ROB   = 2'd2;

  // Any size other than 1 or 2 is served as a full word.
  function automatic logic [2:0] norm_size(input logic [2:0] sz);
    case (sz)
      3'd1:    norm_size = 3'd1;
      3'd2:    norm_size = 3'd2;
      default: norm_size = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [2:0] idx);
    case (idx)
      3'd0:    byte_of = d[7:0];
      3'd1:    byte_of = d[15:8];
      3'd2:    byte_of = d[23:16];
      default: byte_of = d[31:24];
    endcase
  endfunction

  // Bytes above the insertion point are still zero in the buffer.
  function automatic logic [31:0] insert_byte(input logic [31:0] buf_in, input logic [7:0] b,
                                              input logic [2:0] idx);
    case (idx)
      3'd0:    insert_byte = {24'd0, b};
      3'd1:    insert_byte = {16'd0, b, buf_in[7:0]};
      3'd2:    insert_byte = {8'd0, b, buf_in[15:0]};
      default: insert_byte = {b, buf_in[23:0]};
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] sz, input logic sgn);
    case (sz)
      3'd1:    extend = sgn ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
      3'd2:    extend = sgn ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] sel);
    is_io = (sel == IO_BASE[17:16]);
  endfunction

  state_t                r_state, w_nxt_state;
  logic [1:0]            r_who, w_nxt_who;
  logic [2:0]            r_cnt, w_nxt_cnt, r_size, w_nxt_size;
  logic                  r_signed, w_nxt_signed;
  logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
  logic [31:0]           r_wdata, w_nxt_wdata, r_rd_buf, w_nxt_rd_buf;

  logic                  r_fetch_pend, w_nxt_fetch_pend;
  logic [ADDR_WIDTH-1:0] r_fetch_addr, w_nxt_fetch_addr;
  logic                  r_lsb_pend, w_nxt_lsb_pend;
  logic [ADDR_WIDTH-1:0] r_lsb_addr, w_nxt_lsb_addr;
  logic [2:0]            r_lsb_size, w_nxt_lsb_size;
  logic                  r_lsb_signed, w_nxt_lsb_signed;
  logic                  r_rob_pend, w_nxt_rob_pend;
  logic [ADDR_WIDTH-1:0] r_rob_addr, w_nxt_rob_addr;
  logic [2:0]            r_rob_size, w_nxt_rob_size;
  logic [31:0]           r_rob_data, w_nxt_rob_data;

  logic                  r_fetch_ce, w_nxt_fetch_ce, r_lsb_ce, w_nxt_lsb_ce, r_rob_ce, w_nxt_rob_ce;
  logic [31:0]           r_fetch_data, w_nxt_fetch_data, r_lsb_data, w_nxt_lsb_data;
  logic [7:0]            r_ram_data, w_nxt_ram_data;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_nxt_ram_addr;
  logic                  r_ram_wr, w_nxt_ram_wr;

  // A pulse from the requester already pending or currently served is dropped.
  logic w_busy, w_fetch_new, w_lsb_new, w_rob_new, w_fetch_req, w_lsb_req, w_rob_req;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_fetch_new = in_fetch_ce & ~r_fetch_pend & ~(w_busy & (r_who == WHO_FETCH));
  assign w_lsb_new   = in_lsb_ce & ~r_lsb_pend & ~(w_busy & (r_who == WHO_LSB));
  assign w_rob_new   = in_rob_ce & ~r_rob_pend & ~(w_busy & (r_who == WHO_ROB));
  assign w_fetch_req = (r_fetch_pend | w_fetch_new) & ~in_flush;
  assign w_lsb_req   = (r_lsb_pend | w_lsb_new) & ~in_flush;
  assign w_rob_req   = r_rob_pend | w_rob_new;

  // Grant operands come from the latched request, or straight from the port
  // when the request arrives on the arbitration edge itself.
  logic [ADDR_WIDTH-1:0] w_fetch_addr_sel, w_lsb_addr_sel, w_rob_addr_sel;
  logic [2:0]            w_lsb_size_sel, w_rob_size_sel;
  logic                  w_lsb_signed_sel;
  logic [31:0]           w_rob_data_sel;
  assign w_fetch_addr_sel = r_fetch_pend ? r_fetch_addr : in_fetch_addr;
  assign w_lsb_addr_sel   = r_lsb_pend ? r_lsb_addr : in_lsb_addr;
  assign w_lsb_size_sel   = r_lsb_pend ? r_lsb_size : in_lsb_size;
  assign w_lsb_signed_sel = r_lsb_pend ? r_lsb_signed : in_lsb_signed;
  assign w_rob_addr_sel   = r_rob_pend ? r_rob_addr : in_rob_addr;
  assign w_rob_size_sel   = r_rob_pend ? r_rob_size : in_rob_size;
  assign w_rob_data_sel   = r_rob_pend ? r_rob_data : in_rob_data;

  logic                  w_last, w_io_stall, w_rob_stall0;
  logic [2:0]            w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [31:0]           w_rd_word;
  assign w_last       = (r_cnt == (r_size - 3'd1));
  assign w_cnt_inc    = r_cnt + 3'd1;
  assign w_addr_inc   = r_addr + ADDR_WIDTH'(w_cnt_inc);
  assign w_rd_word    = insert_byte(r_rd_buf, in_ram_data, r_cnt);
  assign w_io_stall   = is_io(r_addr[17:16]) & in_io_buffer_full;
  assign w_rob_stall0 = is_io(w_rob_addr_sel[17:16]) & in_io_buffer_full;

  // Next-state, pending capture, arbitration and beat sequencing.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_who        = r_who;
    w_nxt_cnt        = r_cnt;
    w_nxt_size       = r_size;
    w_nxt_signed     = r_signed;
    w_nxt_addr       = r_addr;
    w_nxt_wdata      = r_wdata;
    w_nxt_rd_buf     = r_rd_buf;
    w_nxt_fetch_pend = r_fetch_pend;
    w_nxt_fetch_addr = r_fetch_addr;
    w_nxt_lsb_pend   = r_lsb_pend;
    w_nxt_lsb_addr   = r_lsb_addr;
    w_nxt_lsb_size   = r_lsb_size;
    w_nxt_lsb_signed = r_lsb_signed;
    w_nxt_rob_pend   = r_rob_pend;
    w_nxt_rob_addr   = r_rob_addr;
    w_nxt_rob_size   = r_rob_size;
    w_nxt_rob_data   = r_rob_data;
    w_nxt_fetch_ce   = 1'b0;
    w_nxt_lsb_ce     = 1'b0;
    w_nxt_rob_ce     = 1'b0;
    w_nxt_fetch_data = r_fetch_data;
    w_nxt_lsb_data   = r_lsb_data;
    w_nxt_ram_data   = r_ram_data;
    w_nxt_ram_addr   = r_ram_addr;
    w_nxt_ram_wr     = r_ram_wr;

    if (in_flush) begin
      w_nxt_fetch_pend = 1'b0;
      w_nxt_lsb_pend   = 1'b0;
    end else begin
      if (w_fetch_new) begin
        w_nxt_fetch_pend = 1'b1;
        w_nxt_fetch_addr = in_fetch_addr;
      end else begin
        w_nxt_fetch_pend = r_fetch_pend;
      end
      if (w_lsb_new) begin
        w_nxt_lsb_pend   = 1'b1;
        w_nxt_lsb_addr   = in_lsb_addr;
        w_nxt_lsb_size   = in_lsb_size;
        w_nxt_lsb_signed = in_lsb_signed;
      end else begin
        w_nxt_lsb_pend = r_lsb_pend;
      end
    end
    if (w_rob_new) begin
      w_nxt_rob_pend = 1'b1;
      w_nxt_rob_addr = in_rob_addr;
      w_nxt_rob_size = in_rob_size;
      w_nxt_rob_data = in_rob_data;
    end else begin
      w_nxt_rob_pend = r_rob_pend;
    end

    case (r_state)
      ST_IDLE: begin
        w_nxt_ram_wr   = 1'b0;
        w_nxt_ram_addr = {ADDR_WIDTH{1'b0}};
        w_nxt_cnt      = 3'd0;
        w_nxt_rd_buf   = 32'd0;
        if (w_rob_req) begin
          w_nxt_rob_pend = 1'b0;
          w_nxt_who      = WHO_ROB;
          w_nxt_state    = ST_WRITE;
          w_nxt_addr     = w_rob_addr_sel;
          w_nxt_size     = norm_size(w_rob_size_sel);
          w_nxt_wdata    = w_rob_data_sel;
          w_nxt_ram_addr = w_rob_addr_sel;
          w_nxt_ram_data = w_rob_data_sel[7:0];
          w_nxt_ram_wr   = ~w_rob_stall0;
        end else if (w_lsb_req) begin
          w_nxt_lsb_pend = 1'b0;
          w_nxt_who      = WHO_LSB;
          w_nxt_state    = ST_READ;
          w_nxt_addr     = w_lsb_addr_sel;
          w_nxt_size     = norm_size(w_lsb_size_sel);
          w_nxt_signed   = w_lsb_signed_sel;
          w_nxt_ram_addr = w_lsb_addr_sel;
        end else if (w_fetch_req) begin
          w_nxt_fetch_pend = 1'b0;
          w_nxt_who        = WHO_FETCH;
          w_nxt_state      = ST_READ;
          w_nxt_addr       = w_fetch_addr_sel;
          w_nxt_size       = 3'd4;
          w_nxt_signed     = 1'b0;
          w_nxt_ram_addr   = w_fetch_addr_sel;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (in_flush) begin
          w_nxt_state    = ST_IDLE;
          w_nxt_ram_addr = {ADDR_WIDTH{1'b0}};
          w_nxt_cnt      = 3'd0;
        end else if (w_last) begin
          w_nxt_state    = ST_IDLE;
          w_nxt_ram_addr = {ADDR_WIDTH{1'b0}};
          w_nxt_cnt      = 3'd0;
          if (r_who == WHO_FETCH) begin
            w_nxt_fetch_ce   = 1'b1;
            w_nxt_fetch_data = w_rd_word;
          end else begin
            w_nxt_lsb_ce   = 1'b1;
            w_nxt_lsb_data = extend(w_rd_word, r_size, r_signed);
          end
        end else begin
          w_nxt_rd_buf   = w_rd_word;
          w_nxt_cnt      = w_cnt_inc;
          w_nxt_ram_addr = w_addr_inc;
        end
      end
      ST_WRITE: begin
        // A beat with out_ram_wr low was held back by a full IO buffer and
        // is retried with the same byte; cnt only moves after a real write.
        if (r_ram_wr) begin
          if (w_last) begin
            w_nxt_state    = ST_IDLE;
            w_nxt_ram_wr   = 1'b0;
            w_nxt_ram_addr = {ADDR_WIDTH{1'b0}};
            w_nxt_cnt      = 3'd0;
            w_nxt_rob_ce   = 1'b1;
          end else begin
            w_nxt_cnt      = w_cnt_inc;
            w_nxt_ram_addr = w_addr_inc;
            w_nxt_ram_data = byte_of(r_wdata, w_cnt_inc);
            w_nxt_ram_wr   = ~w_io_stall;
          end
        end else begin
          w_nxt_ram_wr = ~w_io_stall;
        end
      end
      default: begin
        w_nxt_state    = ST_IDLE;
        w_nxt_ram_wr   = 1'b0;
        w_nxt_ram_addr = {ADDR_WIDTH{1'b0}};
        w_nxt_cnt      = 3'd0;
      end
    endcase
  end

  // State, pending and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_who        <= WHO_FETCH;
      r_cnt        <= 3'd0;
      r_size       <= 3'd0;
      r_signed     <= 1'b0;
      r_addr       <= {ADDR_WIDTH{1'b0}};
      r_wdata      <= 32'd0;
      r_rd_buf     <= 32'd0;
      r_fetch_pend <= 1'b0;
      r_fetch_addr <= {ADDR_WIDTH{1'b0}};
      r_lsb_pend   <= 1'b0;
      r_lsb_addr   <= {ADDR_WIDTH{1'b0}};
      r_lsb_size   <= 3'd0;
      r_lsb_signed <= 1'b0;
      r_rob_pend   <= 1'b0;
      r_rob_addr   <= {ADDR_WIDTH{1'b0}};
      r_rob_size   <= 3'd0;
      r_rob_data   <= 32'd0;
      r_fetch_ce   <= 1'b0;
      r_lsb_ce     <= 1'b0;
      r_rob_ce     <= 1'b0;
      r_fetch_data <= 32'd0;
      r_lsb_data   <= 32'd0;
      r_ram_data   <= 8'd0;
      r_ram_addr   <= {ADDR_WIDTH{1'b0}};
      r_ram_wr     <= 1'b0;
    end else if (rdy) begin
      r_state      <= w_nxt_state;
      r_who        <= w_nxt_who;
      r_cnt        <= w_nxt_cnt;
      r_size       <= w_nxt_size;
      r_signed     <= w_nxt_signed;
      r_addr       <= w_nxt_addr;
      r_wdata      <= w_nxt_wdata;
      r_rd_buf     <= w_nxt_rd_buf;
      r_fetch_pend <= w_nxt_fetch_pend;
      r_fetch_addr <= w_nxt_fetch_addr;
      r_lsb_pend   <= w_nxt_lsb_pend;
      r_lsb_addr   <= w_nxt_lsb_addr;
      r_lsb_size   <= w_nxt_lsb_size;
      r_lsb_signed <= w_nxt_lsb_signed;
      r_rob_pend   <= w_nxt_rob_pend;
      r_rob_addr   <= w_nxt_rob_addr;
      r_rob_size   <= w_nxt_rob_size;
      r_rob_data   <= w_nxt_rob_data;
      r_fetch_ce   <= w_nxt_fetch_ce;
      r_lsb_ce     <= w_nxt_lsb_ce;
      r_rob_ce     <= w_nxt_rob_ce;
      r_fetch_data <= w_nxt_fetch_data;
      r_lsb_data   <= w_nxt_lsb_data;
      r_ram_data   <= w_nxt_ram_data;
      r_ram_addr   <= w_nxt_ram_addr;
      r_ram_wr     <= w_nxt_ram_wr;
    end
  end

  assign out_fetch_ce   = r_fetch_ce;
  assign out_fetch_data = r_fetch_data;
  assign out_lsb_ce     = r_lsb_ce;
  assign out_lsb_data   = r_lsb_data;
  assign out_rob_ce     = r_rob_ce;
  assign out_ram_data   = r_ram_data;
  assign out_ram_addr   = r_ram_addr;
  assign out_ram_wr     = r_ram_wr;

endmodule
